// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
// Multi-cycle command front end for the 16-bit combinational ALU. The block holds
// a small register file and accepts register-to-register ALU commands over a
// valid/ready handshake. For each command it drives the ALU with the operands,
// captures the result and flags, writes the result back to the destination
// register, and returns the result on a valid/ready response channel.
//
// Command flow: IDLE -> DRIVE -> CAPT -> RESP -> IDLE (at most one command per
// four cycles).
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_opc/rd/ra/rb/cin  ALU opcode, destination, operand registers, carry-in
//   ld_en/ld_addr/ld_data host register load, allowed in any state
//   alu_inA/inB/inC/opc   operands and opcode presented to the ALU
//   alu_outW/zer/neg      ALU result and flags
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/zer/neg      captured result and flags, held after the handshake
//   busy                  high whenever a command is in flight
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
   parameter  int W    = 16,
   parameter  int NREG = 8,
   localparam int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_opc,
   input  logic [AW-1:0] cmd_rd,
   input  logic [AW-1:0] cmd_ra,
   input  logic [AW-1:0] cmd_rb,
   input  logic          cmd_cin,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [W-1:0]  ld_data,
   output logic [W-1:0]  alu_inA,
   output logic [W-1:0]  alu_inB,
   output logic          alu_inC,
   output logic [2:0]    alu_opc,
   input  logic [W-1:0]  alu_outW,
   input  logic          alu_zer,
   input  logic          alu_neg,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [W-1:0]  rsp_data,
   output logic          rsp_zer,
   output logic          rsp_neg,
   output logic          busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_CAPT,
      S_RESP
   } state_t;

   // Only the add-with-carry opcode consumes the carry-in.
   localparam logic [2:0] OPC_ADDC = 3'd2;

   state_t          state_q;
   logic [W-1:0]    rf_q [NREG];
   logic [W-1:0]    ina_q;
   logic [W-1:0]    inb_q;
   logic            inc_q;
   logic [2:0]      opc_q;
   logic [AW-1:0]   rd_q;
   logic            rsp_valid_q;
   logic [W-1:0]    rsp_data_q;
   logic            rsp_zer_q;
   logic            rsp_neg_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the register file is built from flops and is deliberately
         // cleared by reset; the host relies on all registers reading zero.
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
         state_q     <= S_IDLE;
         ina_q       <= '0;
         inb_q       <= '0;
         inc_q       <= 1'b0;
         opc_q       <= '0;
         rd_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_zer_q   <= 1'b0;
         rsp_neg_q   <= 1'b0;
      end else begin
         // Host load first: a CAPT writeback to the same register later in this
         // block overrides it.
         // NOTE: with non-blocking assignments the last one to the same
         // element in a block wins, which gives writeback priority here.
         if (ld_en) begin
            rf_q[ld_addr] <= ld_data;
         end

         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  // Operands are sampled from the pre-load register contents,
                  // so a load in the accept cycle is not seen by this command.
                  ina_q   <= rf_q[cmd_ra];
                  inb_q   <= rf_q[cmd_rb];
                  opc_q   <= cmd_opc;
                  inc_q   <= (cmd_opc == OPC_ADDC) ? cmd_cin : 1'b0;
                  rd_q    <= cmd_rd;
                  state_q <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               // ALU inputs have been stable for a full cycle; let it settle.
               state_q <= S_CAPT;
            end
            S_CAPT: begin
               rsp_data_q  <= alu_outW;
               rsp_zer_q   <= alu_zer;
               rsp_neg_q   <= alu_neg;
               rf_q[rd_q]  <= alu_outW;
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign alu_inA   = ina_q;
   assign alu_inB   = inb_q;
   assign alu_inC   = inc_q;
   assign alu_opc   = opc_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_zer   = rsp_zer_q;
   assign rsp_neg   = rsp_neg_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Self-checking bench for alu_cmd_sequencer. A behavioural ALU stub closes the
// loop on the ALU ports. A transaction-level reference model (register array,
// in-flight command record, pending response) is advanced once per cycle, and a
// single compare process checks every DUT output against it on each falling
// edge. Directed scenarios add hand-computed literal expectations; a randomized
// phase follows.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_opc;
   logic [2:0]    cmd_rd;
   logic [2:0]    cmd_ra;
   logic [2:0]    cmd_rb;
   logic          cmd_cin;
   logic          ld_en;
   logic [2:0]    ld_addr;
   logic [W-1:0]  ld_data;
   logic [W-1:0]  alu_inA;
   logic [W-1:0]  alu_inB;
   logic          alu_inC;
   logic [2:0]    alu_opc;
   logic [W-1:0]  alu_outW;
   logic          alu_zer;
   logic          alu_neg;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [W-1:0]  rsp_data;
   logic          rsp_zer;
   logic          rsp_neg;
   logic          busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(.W(W), .NREG(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_opc   (cmd_opc),
      .cmd_rd    (cmd_rd),
      .cmd_ra    (cmd_ra),
      .cmd_rb    (cmd_rb),
      .cmd_cin   (cmd_cin),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .alu_inA   (alu_inA),
      .alu_inB   (alu_inB),
      .alu_inC   (alu_inC),
      .alu_opc   (alu_opc),
      .alu_outW  (alu_outW),
      .alu_zer   (alu_zer),
      .alu_neg   (alu_neg),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_zer   (rsp_zer),
      .rsp_neg   (rsp_neg),
      .busy      (busy)
   );

   // ALU behaviour: returns {zer, neg, result}.
   function automatic logic [17:0] alu_fn(input logic [2:0] opc, input logic [15:0] a,
                                          input logic [15:0] b, input logic c);
      logic signed [15:0] sb;
      logic [15:0]        w;
      sb = b;
      case (opc)
         3'd0:    w = 16'd0 - a;
         3'd1:    w = a + 16'd1;
         3'd2:    w = a + b + {15'd0, c};
         3'd3:    w = a + 16'(sb >>> 1);
         3'd4:    w = a & b;
         3'd5:    w = a | b;
         3'd6:    w = {a[7:0], b[7:0]};
         default: w = 16'd0;
      endcase
      return {(w == 16'd0), w[15], w};
   endfunction

   assign {alu_zer, alu_neg, alu_outW} = alu_fn(alu_opc, alu_inA, alu_inB, alu_inC);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [15:0] m_rf [8];
   bit          m_ok = 1'b0;
   bit          m_busy, m_valid;
   logic [15:0] m_data, m_ina, m_inb, m_res;
   logic        m_zer, m_neg, m_inc, m_rz, m_rn;
   logic [2:0]  m_opc, m_rd;
   int          m_cnt;

   // Check current outputs, then advance the model to what the next rising edge
   // must produce given the inputs now stable.
   always @(negedge clk) begin : cmp
      bit          acc, hs;
      logic [17:0] r;
      if (m_ok) begin
         check("busy",      busy,      m_busy);
         check("cmd_ready", cmd_ready, !m_busy);
         check("rsp_valid", rsp_valid, m_valid);
         check("rsp_data",  rsp_data,  m_data);
         check("rsp_zer",   rsp_zer,   m_zer);
         check("rsp_neg",   rsp_neg,   m_neg);
         check("alu_inA",   alu_inA,   m_ina);
         check("alu_inB",   alu_inB,   m_inb);
         check("alu_inC",   alu_inC,   m_inc);
         check("alu_opc",   alu_opc,   m_opc);
      end
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) m_rf[i] = '0;
         m_busy = 0; m_valid = 0; m_cnt = 0;
         m_data = '0; m_zer = 0; m_neg = 0;
         m_ina = '0; m_inb = '0; m_inc = 0; m_opc = '0; m_rd = '0;
         m_ok = 1'b1;
      end else if (m_ok) begin
         acc = cmd_valid && !m_busy;
         hs  = m_valid && rsp_ready;
         if (acc) begin
            m_ina = m_rf[cmd_ra];
            m_inb = m_rf[cmd_rb];
            m_opc = cmd_opc;
            m_inc = (cmd_opc == 3'd2) ? cmd_cin : 1'b0;
            m_rd  = cmd_rd;
            r = alu_fn(m_opc, m_ina, m_inb, m_inc);
            {m_rz, m_rn, m_res} = r;
         end
         if (ld_en) m_rf[ld_addr] = ld_data;
         // Result lands on the third rising edge counting the accept edge;
         // writeback is applied after the host load so it wins a collision.
         if (m_cnt == 1) begin
            m_rf[m_rd] = m_res;
            m_valid = 1; m_data = m_res; m_zer = m_rz; m_neg = m_rn;
         end
         if (m_cnt > 0) m_cnt--;
         if (acc) begin
            m_cnt  = 2;
            m_busy = 1;
         end
         if (hs) begin
            m_valid = 0;
            m_busy  = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic load(input logic [2:0] a, input logic [15:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   // hold < 0: rsp_ready is already high when the response appears.
   // ld_at: -1 none, 0 accept cycle, k>0 the k-th cycle after accept.
   task automatic do_cmd(input logic [2:0] opc, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic cin, input int hold,
                         input bit keep_valid, input int ld_at, input logic [2:0] la,
                         input logic [15:0] ldd, output logic [15:0] d, output logic z,
                         output logic n, output int lat);
      bit acc;
      bit v;
      int k;
      cmd_valid = 1'b1; cmd_opc = opc; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_cin = cin;
      if (ld_at == 0) begin ld_en = 1'b1; ld_addr = la; ld_data = ldd; end
      acc = 0; k = 0; d = 'x; z = 'x; n = 'x; lat = 0;
      while (!acc && k < 20) begin
         @(negedge clk); acc = cmd_ready;
         @(posedge clk); #1;
         k++;
      end
      cmd_valid = 1'b0; ld_en = 1'b0;
      check("cmd_accepted", acc, 1'b1);
      if (!acc) return;
      if (hold < 0) rsp_ready = 1'b1;
      k = 1; v = 0;
      while (!v && k <= 20) begin
         if (ld_at == k) begin ld_en = 1'b1; ld_addr = la; ld_data = ldd; end
         @(negedge clk);
         v = rsp_valid;
         if (v) begin d = rsp_data; z = rsp_zer; n = rsp_neg; lat = k; end
         @(posedge clk); #1;
         ld_en = 1'b0;
         k++;
      end
      check("rsp_seen", v, 1'b1);
      if (hold < 0) begin
         rsp_ready = 1'b0;
         return;
      end
      if (keep_valid) cmd_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", rsp_valid, 1'b1);
         check("hold_data", {rsp_zer, rsp_neg, rsp_data}, {z, n, d});
         check("hold_cmd_ready", cmd_ready, 1'b0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin : stim
      logic [15:0] d;
      logic        z, n;
      int          lat, cnt;
      rst_n = 0; cmd_valid = 0; cmd_opc = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
      cmd_cin = 0; ld_en = 0; ld_addr = '0; ld_data = '0; rsp_ready = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      @(negedge clk);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_cmd_ready", cmd_ready, 1'b1);
      @(posedge clk); #1;

      // Add with carry, held response, competing command offered meanwhile.
      load(3'd1, 16'h0005); load(3'd2, 16'h0003);
      do_cmd(3'd2, 3'd3, 3'd1, 3'd2, 1'b1, 5, 1'b1, -1, 3'd0, 16'h0, d, z, n, lat);
      check("addc_data", {z, n, d}, {2'b00, 16'h0009});
      check("addc_latency", lat, 3);
      do_cmd(3'd2, 3'd3, 3'd1, 3'd2, 1'b1, 0, 1'b0, -1, 3'd0, 16'h0, d, z, n, lat);
      check("reissue_data", d, 16'h0009);
      do_cmd(3'd5, 3'd3, 3'd3, 3'd3, 1'b0, -1, 1'b0, -1, 3'd0, 16'h0, d, z, n, lat);
      check("r3_readback", d, 16'h0009);

      // Negate and increment wrap-around.
      load(3'd1, 16'h0001);
      do_cmd(3'd0, 3'd4, 3'd1, 3'd0, 1'b0, 0, 1'b0, -1, 3'd0, 16'h0, d, z, n, lat);
      check("neg_data", {z, n, d}, {2'b01, 16'hFFFF});
      do_cmd(3'd1, 3'd4, 3'd4, 3'd0, 1'b0, 0, 1'b0, -1, 3'd0, 16'h0, d, z, n, lat);
      check("inc_wrap", {z, n, d}, {2'b10, 16'h0000});

      // Arithmetic shift-add, byte concatenation, zero opcode.
      load(3'd5, 16'h8004);
      do_cmd(3'd3, 3'd6, 3'd0, 3'd5, 1'b0, 0, 1'b0, -1, 3'd0, 16'h0, d, z, n, lat);
      check("sra_add", {z, n, d}, {2'b01, 16'hC002});
      load(3'd1, 16'h12AB); load(3'd2, 16'h34CD);
      do_cmd(3'd6, 3'd7, 3'd1, 3'd2, 1'b1, 0, 1'b0, -1, 3'd0, 16'h0, d, z, n, lat);
      check("concat", d, 16'hABCD);
      do_cmd(3'd7, 3'd0, 3'd1, 3'd2, 1'b0, 0, 1'b0, -1, 3'd0, 16'h0, d, z, n, lat);
      check("zero_op", {z, n, d}, {2'b10, 16'h0000});

      // Load collides with writeback in CAPT: writeback wins.
      do_cmd(3'd4, 3'd3, 3'd1, 3'd2, 1'b0, 0, 1'b0, 2, 3'd3, 16'hDEAD, d, z, n, lat);
      check("and_data", d, 16'h1089);
      do_cmd(3'd5, 3'd3, 3'd3, 3'd3, 1'b0, 0, 1'b0, -1, 3'd0, 16'h0, d, z, n, lat);
      check("collision_wb_wins", d, 16'h1089);

      // Load of a source register in the accept cycle is not seen.
      do_cmd(3'd5, 3'd6, 3'd1, 3'd1, 1'b0, 0, 1'b0, 0, 3'd1, 16'h5555, d, z, n, lat);
      check("accept_load_old", d, 16'h12AB);
      do_cmd(3'd5, 3'd1, 3'd1, 3'd1, 1'b0, 0, 1'b0, -1, 3'd0, 16'h0, d, z, n, lat);
      check("accept_load_new", d, 16'h5555);

      // Reset during DRIVE aborts the command.
      load(3'd1, 16'h1234);
      cmd_valid = 1; cmd_opc = 3'd5; cmd_rd = 3'd7; cmd_ra = 3'd1; cmd_rb = 3'd1;
      @(negedge clk);
      check("abort_accept", cmd_ready, 1'b1);
      @(posedge clk); #1;
      cmd_valid = 0; rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      check("abort_idle", {busy, rsp_valid, cmd_ready}, 3'b001);
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) cnt++;
      end
      check("abort_no_rsp", cnt, 0);
      @(posedge clk); #1;
      do_cmd(3'd5, 3'd7, 3'd7, 3'd7, 1'b0, 0, 1'b0, -1, 3'd0, 16'h0, d, z, n, lat);
      check("abort_r7_zero", d, 16'h0000);
      do_cmd(3'd5, 3'd1, 3'd1, 3'd1, 1'b0, 0, 1'b0, -1, 3'd0, 16'h0, d, z, n, lat);
      check("abort_r1_zero", d, 16'h0000);

      // Randomized traffic checked by the model.
      repeat (150) begin
         if ($urandom_range(0, 2) == 0) load(3'($urandom), 16'($urandom));
         do_cmd(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)) - 1, 1'b0, int'($urandom_range(0, 4)) - 1,
                3'($urandom), 16'($urandom), d, z, n, lat);
      end

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule
